// File: rtl/bin2bcd_conv.sv
// bin2bcd_conv: sequential unsigned binary to packed BCD converter.
//
// Uses the shift-add-3 (double dabble) algorithm, one input bit per clock.
// A conversion takes BIN_W SHIFT cycles plus one FINISH cycle. The results
// (bcd_out, ovf) are registered and hold between conversions.
//
// Optional build macro:
//   BCD_SATURATE_EN  defined   -> an overflowing result shows all digits 9
//                    undefined -> an overflowing result shows all nibbles 0xE
//
// Parameters:
//   BIN_W       input binary width (>= 2)
//   BCD_DIGITS  digits presented on bcd_out
//   INT_DIGITS  internal scratch digits, 10^INT_DIGITS > 2^BIN_W-1 and
//               INT_DIGITS >= BCD_DIGITS
//
// Ports:
//   clock    in   single clock, posedge
//   reset    in   synchronous active-low reset
//   start    in   request conversion of bin_in (accepted only when idle)
//   bin_in   in   unsigned binary value
//   busy     out  conversion in progress
//   done     out  one-cycle pulse when bcd_out/ovf have just been updated
//   bcd_out  out  packed BCD, most significant digit in the top nibble
//   ovf      out  last result exceeded 10^BCD_DIGITS-1
//   disp_en  out  high once the first result is valid, until reset

module bin2bcd_conv #(
    parameter int unsigned BIN_W      = 16,
    parameter int unsigned BCD_DIGITS = 4,
    parameter int unsigned INT_DIGITS = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd_out,
    output logic                    ovf,
    output logic                    disp_en
);

    localparam int unsigned SCR_W = 4 * INT_DIGITS;
    localparam int unsigned OUT_W = 4 * BCD_DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFinish
    } state_e;

    state_e             state_q, state_d;
    logic [SCR_W-1:0]   scr_q, scr_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               disp_q, disp_d;
    logic [OUT_W-1:0]   bcd_q, bcd_d;

    logic [SCR_W-1:0]   scr_adj;
    logic               ovf_n;
    logic [OUT_W-1:0]   ovf_code;
    logic               unused_scr_msb;

    // Pre-shift correction: every digit >= 5 gets +3 so that the following
    // left shift carries correctly into the next decimal digit.
    always_comb begin
        scr_adj = scr_q;
        for (int i = 0; i < int'(INT_DIGITS); i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // The top bit of the corrected scratch falls off the shift; it is always
    // zero when INT_DIGITS is large enough for BIN_W.
    assign unused_scr_msb = scr_adj[SCR_W-1];

    // Overflow: any scratch digit above the presented ones is nonzero.
    if (INT_DIGITS > BCD_DIGITS) begin : g_ovf
        assign ovf_n = |scr_q[SCR_W-1:OUT_W];
    end else begin : g_no_ovf
        assign ovf_n = 1'b0;
    end

`ifdef BCD_SATURATE_EN
    assign ovf_code = {BCD_DIGITS{4'h9}};
`else
    // 0xE per nibble renders as "E" on the hex seven-segment decoder.
    assign ovf_code = {BCD_DIGITS{4'hE}};
`endif

    always_comb begin
        state_d = state_q;
        scr_d   = scr_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        disp_d  = disp_q;
        bcd_d   = bcd_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    bin_d   = bin_in;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    busy_d  = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                scr_d = {scr_adj[SCR_W-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                bcd_d   = ovf_n ? ovf_code : scr_q[OUT_W-1:0];
                ovf_d   = ovf_n;
                done_d  = 1'b1;
                disp_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            scr_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            disp_q  <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            scr_q   <= scr_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;
    assign disp_en = disp_q;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// tb_bin2bcd_conv: scoreboard bench for bin2bcd_conv (default parameters).
// Stimulus pushes the expected {bcd_out, ovf} when it issues a conversion;
// a monitor pops and compares on every done pulse.

module tb_bin2bcd_conv;

`ifdef BCD_SATURATE_EN
    localparam logic [15:0] OVF_CODE = 16'h9999;
`else
    localparam logic [15:0] OVF_CODE = 16'hEEEE;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bin_in = '0;
    logic        busy, done, ovf, disp_en;
    logic [15:0] bcd_out;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [15:0] val;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clock = ~clock;

    bin2bcd_conv dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf),
        .disp_en (disp_en)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits of v, or the overflow code above 9999.
    function automatic exp_t model(input int v);
        exp_t e;
        int   r;
        if (v > 9999) begin
            e.bcd = OVF_CODE;
            e.ovf = 1'b1;
        end else begin
            r = v;
            for (int i = 0; i < 4; i++) begin
                e.bcd[4*i +: 4] = 4'(r % 10);
                r = r / 10;
            end
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got bcd_out %0h with no conversion pending", bcd_out);
            end else begin
                mon_e = sb_q.pop_front();
                check("bcd_out", 32'(bcd_out), 32'(mon_e.bcd));
                check("ovf", 32'(ovf), 32'(mon_e.ovf));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // Called just after the accepting edge; returns at the negedge where done
    // is high (lat = cycles after the accepting edge) or lat = -1 on timeout.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat = -1;
        busy_cyc = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                lat = j;
                break;
            end
            if (busy === 1'b1) busy_cyc++;
        end
    endtask

    task automatic run_conv(input logic [15:0] v, input exp_t e);
        int lat, bc;
        @(negedge clock);
        start  = 1'b1;
        bin_in = v;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        start  = 1'b0;
        bin_in = ~v;  // must be ignored while busy
        wait_done(lat, bc);
        check("latency", 32'(lat), 32'd17);
        check("busy_cycles", 32'(bc), 32'd17);
        @(negedge clock);
        check("done_pulse_width", 32'(done), 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        int lat, bc, ndone;
        exp_t e;

        vecs[0]  = '{16'd0,     16'h0000, 1'b0};
        vecs[1]  = '{16'd1,     16'h0001, 1'b0};
        vecs[2]  = '{16'd9,     16'h0009, 1'b0};
        vecs[3]  = '{16'd10,    16'h0010, 1'b0};
        vecs[4]  = '{16'd99,    16'h0099, 1'b0};
        vecs[5]  = '{16'd100,   16'h0100, 1'b0};
        vecs[6]  = '{16'd4095,  16'h4095, 1'b0};
        vecs[7]  = '{16'd8191,  16'h8191, 1'b0};
        vecs[8]  = '{16'd9999,  16'h9999, 1'b0};
        vecs[9]  = '{16'd10000, OVF_CODE, 1'b1};
        vecs[10] = '{16'd65535, OVF_CODE, 1'b1};
        vecs[11] = '{16'd2048,  16'h2048, 1'b0};

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_bcd_out", 32'(bcd_out), 32'h0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_disp_en", 32'(disp_en), 32'd0);
        reset = 1'b1;

        // Basic conversion
        e.bcd = 16'h1234;
        e.ovf = 1'b0;
        run_conv(16'd1234, e);
        check("disp_en_after_first", 32'(disp_en), 32'd1);
        check("bcd_hold", 32'(bcd_out), 32'h1234);

        // Directed boundary table
        for (int i = 0; i < 12; i++) begin
            e.bcd = vecs[i].bcd;
            e.ovf = vecs[i].ovf;
            run_conv(vecs[i].val, e);
        end

        // Start while busy is ignored, then start in the done cycle is accepted
        @(negedge clock);
        start  = 1'b1;
        bin_in = 16'd42;
        e.bcd = 16'h0042;
        e.ovf = 1'b0;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clock);
        start  = 1'b1;
        bin_in = 16'd7;
        @(negedge clock);
        start = 1'b0;
        wait_done(lat, bc);
        check("busy_restart_done_seen", 32'(lat >= 0), 32'd1);
        start  = 1'b1;
        bin_in = 16'd7;
        e.bcd = 16'h0007;
        e.ovf = 1'b0;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(lat, bc);
        check("back_to_back_latency", 32'(lat), 32'd17);
        @(negedge clock);

        // Reset mid-conversion aborts with no done
        @(negedge clock);
        start  = 1'b1;
        bin_in = 16'd500;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (7) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd_out", 32'(bcd_out), 32'h0);
        check("abort_ovf", 32'(ovf), 32'd0);
        check("abort_disp_en", 32'(disp_en), 32'd0);
        ndone = 0;
        repeat (25) begin
            @(negedge clock);
            if (done === 1'b1) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        e.bcd = 16'h0500;
        e.ovf = 1'b0;
        run_conv(16'd500, e);

        // Random values against the decimal reference
        for (int i = 0; i < 200; i++) begin
            int v;
            v = int'($urandom_range(0, 65535));
            run_conv(16'(v), model(v));
        end

        repeat (3) @(negedge clock);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
